mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_pkg.sv | 12 +
 rtl/mul_arbiter_mul.sv | 16 +
 rtl/mul_arbiter_rr_arbiter.sv | 40 ++++
 rtl/mul_arbiter.sv | 64 ++++++
 tb/tb_mul_arbiter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/mul_arbiter_pkg.sv
// mul_arbiter_pkg: shared widths, latency and response record for the multiplier arbiter
package mul_arbiter_pkg;
   localparam int MUL_W   = 18;
   localparam int PROD_W  = 36;
   localparam int MUL_LAT = 5;
   localparam int MAX_IDW = 3;
   typedef struct packed {
      logic               valid;
      logic [MAX_IDW-1:0] id;
      logic [PROD_W-1:0]  data;
   } resp_t;
endpackage

// File: rtl/mul_arbiter_mul.sv
// mul: shared 18x18 unsigned multiplier, fixed 5-cycle latency, data-only pipeline (no reset)
module mul
   import mul_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic [MUL_W-1:0]  a_i,
   input  logic [MUL_W-1:0]  b_i,
   output logic [PROD_W-1:0] p_o
);
   logic [PROD_W-1:0] p_q [MUL_LAT];
   always_ff @(posedge clk) begin
      p_q[0] <= PROD_W'(a_i) * PROD_W'(b_i);
      for (int i = 1; i < MUL_LAT; i++) p_q[i] <= p_q[i-1];
   end
   assign p_o = p_q[MUL_LAT-1];
endmodule

// File: rtl/mul_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with rotating pointer.
// MUL_ARBITER_PRIO0_EN gives requester 0 absolute priority over the rotation.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] valid_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  gnt_id_o
);
   logic [IDW-1:0] ptr_q, ptr_d, idx;
   logic           found;
   always_comb begin
      grant_o  = '0;
      gnt_id_o = '0;
      found    = 1'b0;
      idx      = '0;
`ifdef MUL_ARBITER_PRIO0_EN
      if (valid_i[0]) begin
         grant_o[0] = 1'b1;
         found      = 1'b1;
      end
`endif
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr_q) + k >= NREQ) ? int'(ptr_q) + k - NREQ : int'(ptr_q) + k);
         if (!found && valid_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            gnt_id_o     = idx;
         end
      end
      ptr_d = !found ? ptr_q : (int'(gnt_id_o) == NREQ - 1) ? '0 : gnt_id_o + IDW'(1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: NREQ requesters share one pipelined multiplier; results return after 5 cycles.
// Define MUL_ARBITER_PRIO0_EN to give requester 0 fixed priority.
module mul_arbiter
   import mul_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*MUL_W-1:0] req_a,
   input  logic [NREQ*MUL_W-1:0] req_b,
   output logic                  resp_valid,
   output logic [IDW-1:0]        resp_id,
   output logic [PROD_W-1:0]     resp_data,
   output logic [2:0]            inflight
);
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    gnt_id;
   logic              xfer;
   logic [MUL_W-1:0]  a_sel, b_sel;
   logic [PROD_W-1:0] prod;
   logic [MUL_LAT-1:0] v_q;
   logic [IDW-1:0]    id_q [MUL_LAT];
   logic [2:0]        inflight_q, inflight_d;
   resp_t             resp;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .clk(clk), .rst_n(rst_n), .valid_i(req_valid), .grant_o(grant), .gnt_id_o(gnt_id)
   );

   assign req_ready = grant;
   assign xfer      = |grant;
   assign a_sel     = req_a[int'(gnt_id)*MUL_W +: MUL_W];
   assign b_sel     = req_b[int'(gnt_id)*MUL_W +: MUL_W];

   mul u_mul (.clk(clk), .a_i(a_sel), .b_i(b_sel), .p_o(prod));

   always_comb
      inflight_d = (xfer && !v_q[MUL_LAT-1]) ? inflight_q + 3'd1 :
                   (!xfer && v_q[MUL_LAT-1]) ? inflight_q - 3'd1 : inflight_q;

   // IDs are zeroed on bubbles so resp_id reads 0 whenever resp_valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q        <= '0;
         inflight_q <= '0;
         for (int i = 0; i < MUL_LAT; i++) id_q[i] <= '0;
      end else begin
         v_q        <= {v_q[MUL_LAT-2:0], xfer};
         id_q[0]    <= xfer ? gnt_id : '0;
         for (int i = 1; i < MUL_LAT; i++) id_q[i] <= id_q[i-1];
         inflight_q <= inflight_d;
      end
   end

   assign resp       = '{valid: v_q[MUL_LAT-1], id: MAX_IDW'(id_q[MUL_LAT-1]), data: prod};
   assign resp_valid = resp.valid;
   assign resp_id    = resp.id[IDW-1:0];
   assign resp_data  = resp.data;
   assign inflight   = inflight_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scoreboard bench for mul_arbiter; grant model follows MUL_ARBITER_PRIO0_EN.
module tb_mul_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*18-1:0] req_a = '0;
   logic [NREQ*18-1:0] req_b = '0;
   logic              resp_valid;
   logic [IDW-1:0]    resp_id;
   logic [35:0]       resp_data;
   logic [2:0]        inflight;

   typedef struct {
      int          id;
      logic [35:0] data;
      int          due;
   } exp_t;

   exp_t sb[$];
   int checks = 0, errors = 0, cyc = 0, m_ptr = 0, m_inf = 0;

   mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_id(resp_id),
      .resp_data(resp_data), .inflight(inflight)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int ptr);
      logic [NREQ-1:0] g = '0;
`ifdef MUL_ARBITER_PRIO0_EN
      if (v[0]) return NREQ'(1);
`endif
      for (int k = 0; k < NREQ; k++)
         if (g == '0 && v[(ptr + k) % NREQ]) g[(ptr + k) % NREQ] = 1'b1;
      return g;
   endfunction

   always @(negedge clk) begin : mon
      logic [NREQ-1:0] g;
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         m_ptr = 0;
         m_inf = 0;
         chk("rst_resp_valid", 64'(resp_valid), 0);
         chk("rst_resp_id", 64'(resp_id), 0);
         chk("rst_inflight", 64'(inflight), 0);
      end else begin
         g = model_grant(req_valid, m_ptr);
         chk("grant", 64'(req_ready), 64'(g));
         chk("onehot", 64'($onehot0(req_ready)), 1);
         if (resp_valid) begin
            if (sb.size() == 0) chk("spurious_resp", 64'(resp_valid), 0);
            else begin
               e = sb.pop_front();
               chk("resp_id", 64'(resp_id), 64'(e.id));
               chk("resp_data", 64'(resp_data), 64'(e.data));
               chk("latency", 64'(cyc), 64'(e.due));
            end
         end else begin
            chk("idle_id", 64'(resp_id), 0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               chk("missing_resp", 64'(resp_valid), 1);
               void'(sb.pop_front());
            end
         end
         chk("inflight", 64'(inflight), 64'(m_inf));
         m_inf = m_inf + int'(g != '0) - int'(resp_valid);
         for (int i = 0; i < NREQ; i++)
            if (g[i]) begin
               sb.push_back('{i, 36'(req_a[i*18 +: 18]) * 36'(req_b[i*18 +: 18]), cyc + 5});
               m_ptr = (i + 1) % NREQ;
            end
      end
   end

   task automatic step(input logic [NREQ-1:0] v);
      @(posedge clk);
      #1 req_valid = v;
   endtask

   task automatic set_op(input int i, input logic [17:0] a, input logic [17:0] b);
      req_a[i*18 +: 18] = a;
      req_b[i*18 +: 18] = b;
   endtask

   task automatic rnd_ops();
      for (int i = 0; i < NREQ; i++) set_op(i, 18'($urandom), 18'($urandom));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step(4'b0001);
      set_op(0, 18'd3, 18'd5);
      repeat (8) step('0);
      for (int n = 0; n < 8; n++) begin
         step('1);
         rnd_ops();
      end
      repeat (8) step('0);
      step(4'b0100);
      set_op(2, 18'h3FFFF, 18'h3FFFF);
      repeat (8) step('0);
      for (int n = 0; n < 60; n++) begin
         step(NREQ'($urandom));
         rnd_ops();
      end
      repeat (8) step('0);
      rnd_ops();
      repeat (3) step('1);
      step('0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) step('0);
      step('1);
      rnd_ops();
      repeat (8) step('0);
      @(negedge clk);
      chk("drain", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
